reg_bus_arbiter: RTL and testbench

//  Shares one register slave bus (req/ack/rd_wr_L/addr/wr_data/rd_data) between two masters:
//  m0 = host CPCI register path, m1 = on-chip management requester. Sits in nf2_core between the

---
 rtl/reg_bus_arbiter_pkg.sv | 7 +
 rtl/reg_bus_arbiter_if.sv | 11 +
 rtl/reg_bus_arbiter_watchdog.sv | 26 ++
 rtl/reg_bus_arbiter.sv | 84 ++++++++
 tb/tb_reg_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bus_arbiter_pkg.sv
// reg_bus_arbiter_pkg: shared register-bus widths, timeout data and arbiter state encoding
package reg_bus_arbiter_pkg;
    localparam int REG_ADDR_WIDTH = 23;
    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA_DEFAULT = 32'hdead_beef;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2, RELEASE = 2'd3} state_t;
endpackage

// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if: one register bus (req/ack handshake, address, write and read data)
interface reg_bus_arbiter_if import reg_bus_arbiter_pkg::*;;
    logic req;
    logic ack;
    logic rd_wr_L;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    modport master (output req, rd_wr_L, addr, wr_data, input ack, rd_data);
    modport slave (input req, rd_wr_L, addr, wr_data, output ack, rd_data);
endinterface

// File: rtl/reg_bus_arbiter_watchdog.sv
// reg_bus_watchdog: access-length watchdog with expire pulse and saturating timeout counter
module reg_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        suppress,
    output logic        expire,
    output logic [15:0] count
);
    logic [15:0] wd;
    assign expire = enable && wd == 16'(TIMEOUT_CYCLES);
    // watchdog restarts at 1 for the first cycle of an access; an expiry beaten by an ack is not counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd <= '0;
            count <= '0;
        end else begin
            wd <= clear ? 16'd1 : enable ? wd + 16'd1 : wd;
            if (expire && !suppress && count != 16'hffff)
                count <= count + 16'd1;
        end
    end
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sharing of one register slave bus between two masters
module reg_bus_arbiter import reg_bus_arbiter_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    reg_bus_arbiter_if.slave   m0,
    reg_bus_arbiter_if.slave   m1,
    reg_bus_arbiter_if.master  s,
    output logic [15:0]        timeout_count
);
    state_t state, nxt;
    logic ptr, gnt, pick, any_req, gnt_req, expire, ack0, ack1;
    logic rd_wr_l_q;
    logic [REG_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q, cap, held0, held1;

    assign any_req = m0.req | m1.req;
    assign pick = (m0.req & m1.req) ? ptr : m1.req;
    assign gnt_req = gnt ? m1.req : m0.req;
    assign ack0 = (state == RESP) & ~gnt & m0.req;
    assign ack1 = (state == RESP) & gnt & m1.req;

    assign s.req = state == ISSUE;
    assign s.rd_wr_L = rd_wr_l_q;
    assign s.addr = addr_q;
    assign s.wr_data = wr_data_q;
    assign m0.ack = ack0;
    assign m1.ack = ack1;
    assign m0.rd_data = ack0 ? cap : held0;
    assign m1.rd_data = ack1 ? cap : held1;

    reg_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk(clk),
        .reset(reset),
        .clear(state == IDLE && any_req),
        .enable(state == ISSUE),
        .suppress(s.ack),
        .expire(expire),
        .count(timeout_count)
    );

    // next state: one access in flight, then wait for the granted master to let go
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = any_req ? ISSUE : IDLE;
            ISSUE:   nxt = (s.ack || expire) ? RESP : ISSUE;
            RESP:    nxt = RELEASE;
            default: nxt = gnt_req ? RELEASE : IDLE;
        endcase
    end

    // state, grant pointer, slave-side request copy and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr <= 1'b0;
            gnt <= 1'b0;
            rd_wr_l_q <= 1'b0;
            addr_q <= '0;
            wr_data_q <= '0;
            cap <= '0;
            held0 <= '0;
            held1 <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && any_req) begin
                gnt <= pick;
                ptr <= ~pick;
                rd_wr_l_q <= pick ? m1.rd_wr_L : m0.rd_wr_L;
                addr_q <= pick ? m1.addr : m0.addr;
                wr_data_q <= pick ? m1.wr_data : m0.wr_data;
            end
            if (state == ISSUE && (s.ack || expire))
                cap <= s.ack ? s.rd_data : TIMEOUT_DATA;
            if (ack0)
                held0 <= cap;
            if (ack1)
                held1 <= cap;
        end
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed and randomized checks of the two-master register bus arbiter
module tb_reg_bus_arbiter;
    localparam int TC = 64;
    localparam logic [31:0] DEAD = 32'hdead_beef;

    logic clk = 0;
    logic reset;
    logic [15:0] timeout_count;
    reg_bus_arbiter_if m0_if();
    reg_bus_arbiter_if m1_if();
    reg_bus_arbiter_if s_if();

    int total = 0;
    int bad = 0;
    int slv_ack_at = 0;
    int hi_cnt = 0;
    logic slv_ack = 0;
    logic spur = 0;
    logic [31:0] slv_data = 0;
    int exp_ptr = 0;
    logic [15:0] exp_tc = 0;
    logic [31:0] exp_hold [2];
    int low_run = 100;
    logic prev_sreq = 0;
    logic [1:0] sel;
    int aa;
    bit ok, other;

    reg_bus_arbiter dut (
        .clk(clk),
        .reset(reset),
        .m0(m0_if),
        .m1(m1_if),
        .s(s_if),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    assign s_if.ack = slv_ack | spur;
    assign s_if.rd_data = slv_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // edge-triggered slave: acks once, slv_ack_at cycles into each s_req high period (0 = never)
    initial begin
        forever begin
            @(posedge clk);
            #1;
            hi_cnt = s_if.req ? hi_cnt + 1 : 0;
            slv_ack = s_if.req && slv_ack_at != 0 && hi_cnt == slv_ack_at;
        end
    end

    // every s_req rise must follow at least two low cycles
    always @(negedge clk) begin
        if (s_if.req && !prev_sreq)
            chk("s_req_gap", low_run >= 2, 1);
        low_run = s_if.req ? 0 : low_run + 1;
        prev_sreq = s_if.req;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic wait_ack(input int n, output bit got, output bit oth);
        got = 0;
        oth = 0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (n == 1 ? m0_if.ack : m1_if.ack) oth = 1;
            if (n == 1 ? m1_if.ack : m0_if.ack) got = 1;
        end
    endtask

    task automatic run_txn(input bit r0, input bit r1, input logic rw0, input logic rw1,
                           input logic [22:0] a0, input logic [22:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int ack_at, input logic [31:0] sdata);
        int order[$];
        int k, cyc, rise_cyc, g;
        bit drop0, drop1, first, prev, to;
        logic [31:0] expd;
        to = ack_at == 0 || ack_at > TC;
        k = to ? TC : ack_at;
        expd = to ? DEAD : sdata;
        slv_ack_at = ack_at;
        slv_data = sdata;
        if (r0 && r1) begin
            order.push_back(exp_ptr);
            order.push_back(1 - exp_ptr);
        end else
            order.push_back(r1 ? 1 : 0);
        m0_if.rd_wr_L = rw0; m0_if.addr = a0; m0_if.wr_data = d0; m0_if.req = r0;
        m1_if.rd_wr_L = rw1; m1_if.addr = a1; m1_if.wr_data = d1; m1_if.req = r1;
        cyc = 0; rise_cyc = 0; first = 1; prev = 0;
        for (int t = 0; t < 400 && order.size() > 0; t++) begin
            @(negedge clk);
            drop0 = 0;
            drop1 = 0;
            if (s_if.req && !prev) begin
                g = order[0];
                chk("s_addr", s_if.addr, g ? a1 : a0);
                chk("s_rd_wr_L", s_if.rd_wr_L, g ? rw1 : rw0);
                chk("s_wr_data", s_if.wr_data, g ? d1 : d0);
                if (first) chk("first_issue_cycle", cyc, 1);
                first = 0;
                rise_cyc = cyc;
                exp_ptr = 1 - g;
            end
            prev = s_if.req;
            if (m0_if.ack || m1_if.ack) begin
                g = order[0];
                chk("ack_who", {m1_if.ack, m0_if.ack}, g ? 2 : 1);
                chk("rd_data", g ? m1_if.rd_data : m0_if.rd_data, expd);
                chk("latency", cyc - rise_cyc, k);
                if (to) exp_tc = (exp_tc == 16'hffff) ? exp_tc : exp_tc + 16'd1;
                chk("timeout_count", timeout_count, exp_tc);
                exp_hold[g] = expd;
                if (g == 0) drop0 = 1; else drop1 = 1;
                void'(order.pop_front());
            end
            @(posedge clk);
            #1;
            if (drop0) m0_if.req = 0;
            if (drop1) m1_if.req = 0;
            cyc++;
        end
        chk("txn_complete", order.size(), 0);
        m0_if.req = 0;
        m1_if.req = 0;
        repeat (3) begin
            @(negedge clk);
            chk("no_extra_ack", {m1_if.ack, m0_if.ack}, 0);
        end
        chk("m0_rd_data_held", m0_if.rd_data, exp_hold[0]);
        chk("m1_rd_data_held", m1_if.rd_data, exp_hold[1]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        exp_hold[0] = 0;
        exp_hold[1] = 0;
        m0_if.req = 0; m0_if.rd_wr_L = 0; m0_if.addr = 0; m0_if.wr_data = 0;
        m1_if.req = 0; m1_if.rd_wr_L = 0; m1_if.addr = 0; m1_if.wr_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_req", s_if.req, 0);
        chk("rst_s_addr", s_if.addr, 0);
        chk("rst_s_rd_wr_L", s_if.rd_wr_L, 0);
        chk("rst_s_wr_data", s_if.wr_data, 0);
        chk("rst_acks", {m1_if.ack, m0_if.ack}, 0);
        chk("rst_m0_rd_data", m0_if.rd_data, 0);
        chk("rst_m1_rd_data", m1_if.rd_data, 0);
        chk("rst_timeout_count", timeout_count, 0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;

        // single m0 read, slave acks in the second s_req cycle
        run_txn(1, 0, 1, 0, 23'h000100, 23'h0, 32'h0, 32'h0, 2, 32'h12345678);

        // contention: both request every time, grants alternate
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 23'($urandom), 23'($urandom),
                    $urandom, $urandom, $urandom_range(1, 4), $urandom);

        // unacked m1 write times out, then a normal access
        run_txn(0, 1, 1, 0, 23'h0, 23'h7fffff, 32'h0, 32'ha5a5a5a5, 0, 32'h99999999);
        run_txn(1, 0, 1, 1, 23'h000222, 23'h0, 32'h0, 32'h0, 3, 32'h5a5a0001);

        // ack in the very cycle the watchdog expires
        run_txn(1, 0, 1, 1, 23'h000333, 23'h0, 32'h0, 32'h0, TC, 32'hcafef00d);

        // spurious slave acks during RELEASE and IDLE
        m0_if.rd_wr_L = 1; m0_if.addr = 23'h55; slv_ack_at = 1; slv_data = 32'h0badf00d;
        m0_if.req = 1;
        wait_ack(0, ok, other);
        chk("spur_setup_ack", ok, 1);
        chk("spur_setup_data", m0_if.rd_data, 32'h0badf00d);
        exp_hold[0] = 32'h0badf00d;
        exp_ptr = 1;
        @(posedge clk); #1;
        spur = 1;
        repeat (3) begin
            @(negedge clk);
            chk("spur_release_ack", {m1_if.ack, m0_if.ack}, 0);
            chk("spur_release_sreq", s_if.req, 0);
        end
        @(posedge clk); #1;
        spur = 0;
        m0_if.req = 0;
        repeat (2) @(posedge clk);
        #1;
        spur = 1;
        repeat (2) begin
            @(negedge clk);
            chk("spur_idle_ack", {m1_if.ack, m0_if.ack}, 0);
            chk("spur_idle_sreq", s_if.req, 0);
        end
        @(posedge clk); #1;
        spur = 0;
        @(posedge clk); #1;
        chk("spur_m0_rd_data", m0_if.rd_data, exp_hold[0]);
        run_txn(0, 1, 0, 1, 23'h0, 23'h000abc, 32'h0, 32'h0, 1, 32'h77665544);

        // m0 abandons its request mid-access; pending m1 then served
        m0_if.rd_wr_L = 1; m0_if.addr = 23'h200; slv_ack_at = 5; slv_data = 32'h11112222;
        m0_if.req = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_sreq_high", s_if.req, 1);
        m0_if.req = 0;
        m1_if.rd_wr_L = 0; m1_if.addr = 23'h300; m1_if.wr_data = 32'h3333;
        m1_if.req = 1;
        wait_ack(1, ok, other);
        chk("abort_m1_ack", ok, 1);
        chk("abort_no_m0_ack", other, 0);
        chk("abort_m1_rd_data", m1_if.rd_data, 32'h11112222);
        chk("abort_m0_rd_data", m0_if.rd_data, exp_hold[0]);
        chk("abort_s_addr", s_if.addr, 23'h300);
        exp_hold[1] = 32'h11112222;
        exp_ptr = 0;
        @(posedge clk); #1;
        m1_if.req = 0;
        repeat (2) @(posedge clk);
        #1;

        // asynchronous reset in the middle of an access
        m0_if.rd_wr_L = 1; m0_if.addr = 23'h444; slv_ack_at = 0;
        m0_if.req = 1;
        repeat (6) @(negedge clk);
        chk("pre_reset_sreq", s_if.req, 1);
        #2;
        reset = 1;
        m0_if.req = 0;
        #1;
        chk("async_rst_sreq", s_if.req, 0);
        chk("async_rst_acks", {m1_if.ack, m0_if.ack}, 0);
        chk("async_rst_timeout_count", timeout_count, 0);
        chk("async_rst_s_addr", s_if.addr, 0);
        chk("async_rst_m0_rd_data", m0_if.rd_data, 0);
        exp_ptr = 0;
        exp_tc = 0;
        exp_hold[0] = 0;
        exp_hold[1] = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        run_txn(1, 1, 1, 1, 23'h000100, 23'h000101, 32'h0, 32'h0, 2, 32'h12345678);
        run_txn(1, 0, 1, 0, 23'h000100, 23'h0, 32'h0, 32'h0, 2, 32'h12345678);

        // randomized traffic
        for (int i = 0; i < 20; i++) begin
            sel = 2'($urandom_range(1, 3));
            aa = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            run_txn(sel[0], sel[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    23'($urandom), 23'($urandom), $urandom, $urandom, aa, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
